// File: rtl/ctrl_seq_decoder.sv
// ctrl_seq_decoder
//   Registered, valid/ready handshaked control decoder. It takes one
//   instruction per transfer and presents the decoded datapath control
//   bundle one cycle later, for one ISSUE cycle. Memory ops are held for
//   MEM_LAT extra cycles (MEM_WAIT), and fetch is stalled while they are
//   held. PC select is resolved for EQ branches and JAL.
// Ports
//   Clk, Reset           clock (rising edge), synchronous active-high reset
//   instr_valid/instr    fetch side request
//   instr_ready          accept, combinational from state
//   alu_zero             ALU zero flag, used during ISSUE
//   ctl_valid            bundle valid (ISSUE only)
//   Branch..RegWrite     1-bit control outputs
//   ALUOp                ALU operation
//   pc_sel               ISSUE & (Jump | Branch & alu_zero)
//   mem_busy             high in MEM_WAIT
//   n_issued, n_stall    saturating ISSUE/MEM_WAIT cycle counters
//                        (present only with CTRL_PERF_CNT_EN defined)
module ctrl_seq_decoder #(
    parameter int IW      = 9,
    parameter int OPW     = 3,
    parameter int ALUW    = 4,
    parameter int MEM_LAT = 2,
    parameter int CNTW    = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            instr_valid,
    input  logic [IW-1:0]   instr,
    output logic            instr_ready,
    input  logic            alu_zero,
    output logic            ctl_valid,
    output logic            Branch,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            Reg_Size,
    output logic            Func_Ex,
    output logic            Jump,
    output logic            ALUSrc,
    output logic            RegWrite,
    output logic [ALUW-1:0] ALUOp,
    output logic            pc_sel,
    output logic            mem_busy
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNTW-1:0] n_issued,
    output logic [CNTW-1:0] n_stall
`endif
);

    localparam logic [ALUW-1:0] kADD   = ALUW'(0);
    localparam logic [ALUW-1:0] kSUB   = ALUW'(1);
    localparam logic [ALUW-1:0] kAND   = ALUW'(2);
    localparam logic [ALUW-1:0] kNOT   = ALUW'(3);
    localparam logic [ALUW-1:0] kBXOR  = ALUW'(4);
    localparam logic [ALUW-1:0] kRXOR  = ALUW'(5);
    localparam logic [ALUW-1:0] kSHIFT = ALUW'(6);
    localparam logic [ALUW-1:0] kMOV   = ALUW'(7);
    localparam logic [ALUW-1:0] kPASS  = ALUW'(8);

    localparam logic [3:0] LAT      = 4'(MEM_LAT);
    localparam bit         HAS_WAIT = (MEM_LAT > 0);

    typedef struct packed {
        logic            branch;
        logic            mem_read;
        logic            mem_write;
        logic            reg_size;
        logic            func_ex;
        logic            jump;
        logic            alu_src;
        logic            reg_write;
        logic [ALUW-1:0] alu_op;
    } ctl_t;

    localparam ctl_t CTL_SAFE = '{branch: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                  reg_size: 1'b0, func_ex: 1'b0, jump: 1'b0,
                                  alu_src: 1'b0, reg_write: 1'b0, alu_op: kPASS};

    typedef enum logic [1:0] {IDLE, ISSUE, MEM_WAIT} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    ctl_t            ctl_q, ctl_d, dec;
    logic [OPW-1:0]  opcode;
    logic [1:0]      funct;
    logic            unused_ok;

    assign opcode    = instr[IW-1 -: OPW];
    assign funct     = instr[1:0];
    // middle instruction bits carry operands, not control
    assign unused_ok = ^instr[IW-OPW-1:2];

    // combinational decode of the presented instruction
    always_comb begin
        dec           = CTL_SAFE;
        dec.reg_size  = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        case (opcode)
            OPW'(0): begin
                case (funct)
                    2'b00: begin
                        dec.alu_op = kADD; dec.mem_read = 1'b1;
                        dec.alu_src = 1'b0; dec.func_ex = 1'b1;
                    end
                    2'b01: begin
                        dec.alu_op = kADD; dec.mem_write = 1'b1;
                        dec.alu_src = 1'b0; dec.func_ex = 1'b1; dec.reg_write = 1'b0;
                    end
                    2'b10:   dec.alu_op = kNOT;
                    default: begin dec.alu_op = kBXOR; dec.reg_size = 1'b0; end
                endcase
            end
            OPW'(1): begin dec.alu_op = kSUB; dec.branch = 1'b1; dec.reg_write = 1'b0; end
            OPW'(2): begin
                dec.reg_size = 1'b0;
                dec.alu_op   = funct[1] ? kSUB : kADD;
                dec.alu_src  = ~funct[0];   // f01/f11 are the immediate forms
            end
            OPW'(3): begin dec.alu_op = kPASS; dec.jump = 1'b1; end
            OPW'(4): dec.alu_op = kMOV;
            OPW'(5): dec.alu_op = kAND;
            OPW'(6): begin dec.alu_op = kSHIFT; dec.alu_src = 1'b0; end
            default: dec.alu_op = kRXOR;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctl_d       = ctl_q;
        instr_ready = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = ISSUE;
                    ctl_d   = dec;
                end
            end
            ISSUE: begin
                if (HAS_WAIT && (ctl_q.mem_read || ctl_q.mem_write)) begin
                    state_d = MEM_WAIT;
                    cnt_d   = LAT;
                end else begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        ctl_d = dec;
                    end else begin
                        state_d = IDLE;
                        ctl_d   = CTL_SAFE;
                    end
                end
            end
            MEM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // last wait cycle accepts the next instruction
                if (cnt_q == 4'd1) begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        state_d = ISSUE;
                        ctl_d   = dec;
                    end else begin
                        state_d = IDLE;
                        ctl_d   = CTL_SAFE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ctl_d   = CTL_SAFE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctl_q   <= CTL_SAFE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
        end
    end

    assign ctl_valid = (state_q == ISSUE);
    assign mem_busy  = (state_q == MEM_WAIT);
    assign Branch    = ctl_q.branch;
    assign MemRead   = ctl_q.mem_read;
    assign MemWrite  = ctl_q.mem_write;
    assign Reg_Size  = ctl_q.reg_size;
    assign Func_Ex   = ctl_q.func_ex;
    assign Jump      = ctl_q.jump;
    assign ALUSrc    = ctl_q.alu_src;
    assign RegWrite  = ctl_q.reg_write;
    assign ALUOp     = ctl_q.alu_op;
    assign pc_sel    = ctl_valid & (ctl_q.jump | (ctl_q.branch & alu_zero));

`ifdef CTRL_PERF_CNT_EN
    logic [CNTW-1:0] n_issued_q, n_stall_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            n_issued_q <= '0;
            n_stall_q  <= '0;
        end else begin
            if (ctl_valid && !(&n_issued_q)) n_issued_q <= n_issued_q + 1'b1;
            if (mem_busy  && !(&n_stall_q))  n_stall_q  <= n_stall_q + 1'b1;
        end
    end

    assign n_issued = n_issued_q;
    assign n_stall  = n_stall_q;
`else
    logic [CNTW-1:0] unused_cntw;
    assign unused_cntw = '0;
`endif

endmodule
